// File: rtl/axis_frame_decoder.sv
// Decodes an AXI-stream of two-color pixels into WIDTH-bit rows and hands each
// row to a consumer. It also counts frames and keeps sticky framing and color error flags.
module axis_frame_decoder #(
  parameter int                DWIDTH      = 32,
  parameter int                WIDTH       = 8,
  parameter int                HEIGHT      = 1,
  parameter logic [DWIDTH-1:0] ALIVE_COLOR = DWIDTH'(32'hFFFFFFFF),
  parameter logic [DWIDTH-1:0] DEAD_COLOR  = DWIDTH'(32'h00000000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              S_AXIS_TVALID,
  output logic              S_AXIS_TREADY,
  input  logic [DWIDTH-1:0] S_AXIS_TDATA,
  input  logic              S_AXIS_TLAST,
  output logic [WIDTH-1:0]  row_data,
  output logic              row_valid,
  input  logic              row_ready,
  output logic [15:0]       row_index,
  output logic              frame_done,
  output logic [15:0]       frame_count,
  output logic              err_color,
  output logic              err_last_early,
  output logic              err_last_missing,
  input  logic              err_clear
);
  localparam int              PW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [PW-1:0]   LAST_PIX = PW'(WIDTH - 1);
  localparam logic [15:0]     LAST_ROW = 16'(HEIGHT - 1);

  typedef enum logic {COLLECT, PRESENT} state_t;
  state_t        state;
  logic [PW-1:0] pix_cnt;

  logic beat, is_alive, is_bad, last_pix, last_row, early, missing;
  assign beat     = S_AXIS_TVALID & S_AXIS_TREADY;
  assign is_alive = (S_AXIS_TDATA == ALIVE_COLOR);
  assign is_bad   = !is_alive && (S_AXIS_TDATA != DEAD_COLOR);
  assign last_pix = (pix_cnt == LAST_PIX);
  assign last_row = (row_index == LAST_ROW);
  // TLAST is only legal on the final pixel of the final row.
  assign early    = beat & S_AXIS_TLAST & ~(last_pix & last_row);
  assign missing  = beat & ~S_AXIS_TLAST & last_pix & last_row;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= COLLECT;
      S_AXIS_TREADY    <= 1'b1;
      row_valid        <= 1'b0;
      row_data         <= '0;
      row_index        <= '0;
      pix_cnt          <= '0;
      frame_done       <= 1'b0;
      frame_count      <= '0;
      err_color        <= 1'b0;
      err_last_early   <= 1'b0;
      err_last_missing <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      // A new event wins over a coincident clear.
      err_color        <= (err_color        & ~err_clear) | (beat & is_bad);
      err_last_early   <= (err_last_early   & ~err_clear) | early;
      err_last_missing <= (err_last_missing & ~err_clear) | missing;
      case (state)
        COLLECT: begin
          if (beat) begin
            if (early) begin
              row_data  <= '0;
              pix_cnt   <= '0;
              row_index <= '0;
            end else begin
              row_data[pix_cnt] <= is_alive;
              if (last_pix) begin
                pix_cnt       <= '0;
                state         <= PRESENT;
                S_AXIS_TREADY <= 1'b0;
                row_valid     <= 1'b1;
              end else begin
                pix_cnt <= pix_cnt + 1'b1;
              end
            end
          end
        end
        PRESENT: begin
          if (row_ready) begin
            state         <= COLLECT;
            S_AXIS_TREADY <= 1'b1;
            row_valid     <= 1'b0;
            row_data      <= '0;
            if (last_row) begin
              row_index   <= '0;
              frame_done  <= 1'b1;
              frame_count <= frame_count + 16'd1;
            end else begin
              row_index <= row_index + 16'd1;
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end
endmodule

// File: tb/tb_axis_frame_decoder.sv
// Directed bench: a HEIGHT=1 decoder driven from a frame table plus corner sequences,
// and a HEIGHT=2 decoder for backpressure and multi-row framing.
module tb_axis_frame_decoder;
  localparam logic [31:0] ALIVE = 32'hFFFFFFFF;
  localparam logic [31:0] DEAD  = 32'h00000000;
  localparam logic [31:0] BAD   = 32'h12345678;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_tvalid = 0, a_tlast = 0, a_row_ready = 0, a_err_clear = 0;
  logic [31:0] a_tdata = 0;
  logic        a_tready, a_row_valid, a_frame_done, a_err_color, a_err_early, a_err_missing;
  logic [7:0]  a_row_data;
  logic [15:0] a_row_index, a_frame_count;

  logic        b_tvalid = 0, b_tlast = 0, b_row_ready = 0, b_err_clear = 0;
  logic [31:0] b_tdata = 0;
  logic        b_tready, b_row_valid, b_frame_done, b_err_color, b_err_early, b_err_missing;
  logic [7:0]  b_row_data;
  logic [15:0] b_row_index, b_frame_count;

  axis_frame_decoder #(.DWIDTH(32), .WIDTH(8), .HEIGHT(1)) u_a (
    .clk(clk), .rst(rst),
    .S_AXIS_TVALID(a_tvalid), .S_AXIS_TREADY(a_tready), .S_AXIS_TDATA(a_tdata), .S_AXIS_TLAST(a_tlast),
    .row_data(a_row_data), .row_valid(a_row_valid), .row_ready(a_row_ready), .row_index(a_row_index),
    .frame_done(a_frame_done), .frame_count(a_frame_count),
    .err_color(a_err_color), .err_last_early(a_err_early), .err_last_missing(a_err_missing),
    .err_clear(a_err_clear));

  axis_frame_decoder #(.DWIDTH(32), .WIDTH(8), .HEIGHT(2)) u_b (
    .clk(clk), .rst(rst),
    .S_AXIS_TVALID(b_tvalid), .S_AXIS_TREADY(b_tready), .S_AXIS_TDATA(b_tdata), .S_AXIS_TLAST(b_tlast),
    .row_data(b_row_data), .row_valid(b_row_valid), .row_ready(b_row_ready), .row_index(b_row_index),
    .frame_done(b_frame_done), .frame_count(b_frame_count),
    .err_color(b_err_color), .err_last_early(b_err_early), .err_last_missing(b_err_missing),
    .err_clear(b_err_clear));

  int checks = 0;
  int errors = 0;
  int exp_fc = 0;

  typedef struct {
    int          nbeats;
    logic [7:0]  alive;
    int          bad_idx;
    int          last_idx;
    logic        exp_row;
    logic [7:0]  exp_data;
    logic [2:0]  exp_err;   // {color, early, missing}
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [31:0] d, input logic l);
    a_tvalid = 1'b1; a_tdata = d; a_tlast = l;
    tick();
    a_tvalid = 1'b0; a_tdata = '0; a_tlast = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] d, input logic l);
    b_tvalid = 1'b1; b_tdata = d; b_tlast = l;
    tick();
    b_tvalid = 1'b0; b_tdata = '0; b_tlast = 1'b0;
  endtask

  task automatic send_row_a(input logic [7:0] alive, input int last_idx);
    for (int k = 0; k < 8; k++) send_a(alive[k] ? ALIVE : DEAD, k == last_idx);
  endtask

  task automatic send_row_b(input logic [7:0] alive, input int last_idx);
    for (int k = 0; k < 8; k++) send_b(alive[k] ? ALIVE : DEAD, k == last_idx);
  endtask

  task automatic handshake_a();
    a_row_ready = 1'b1;
    tick();
    a_row_ready = 1'b0;
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_tready"}, 32'(a_tready), 32'd1);
    chk({tag, "_row_valid"}, 32'(a_row_valid), 32'd0);
    chk({tag, "_row_data"}, 32'(a_row_data), 32'd0);
    chk({tag, "_row_index"}, 32'(a_row_index), 32'd0);
    chk({tag, "_frame_done"}, 32'(a_frame_done), 32'd0);
    chk({tag, "_frame_count"}, 32'(a_frame_count), 32'd0);
    chk({tag, "_errs"}, 32'({a_err_color, a_err_early, a_err_missing}), 32'd0);
  endtask

  initial begin
    vecs[0] = '{8, 8'h85, -1,  7, 1'b1, 8'h85, 3'b000};
    vecs[1] = '{8, 8'hFF, -1,  7, 1'b1, 8'hFF, 3'b000};
    vecs[2] = '{8, 8'hAA, -1,  7, 1'b1, 8'hAA, 3'b000};
    vecs[3] = '{8, 8'hFF,  3,  7, 1'b1, 8'hF7, 3'b100};
    vecs[4] = '{8, 8'h01, -1, -1, 1'b1, 8'h01, 3'b001};
    vecs[5] = '{3, 8'hFF, -1,  2, 1'b0, 8'h00, 3'b010};
    vecs[6] = '{8, 8'h0F, -1,  7, 1'b1, 8'h0F, 3'b000};

    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk_reset_a("reset");
    chk("reset_b_tready", 32'(b_tready), 32'd1);

    // HEIGHT=2: backpressure on row 0, frame completes only after row 1
    send_row_b(8'h3C, -1);
    chk("b_r0_valid", 32'(b_row_valid), 32'd1);
    chk("b_r0_index", 32'(b_row_index), 32'd0);
    for (int c = 0; c < 5; c++) begin
      chk("b_stall_tready", 32'(b_tready), 32'd0);
      chk("b_stall_data", 32'(b_row_data), 32'h3C);
      tick();
    end
    b_row_ready = 1'b1;
    tick();
    b_row_ready = 1'b0;
    chk("b_r0_no_done", 32'(b_frame_done), 32'd0);
    chk("b_r0_next_index", 32'(b_row_index), 32'd1);
    chk("b_r0_released", 32'({b_row_valid, b_tready}), 32'b01);
    send_row_b(8'hC3, 7);
    chk("b_r1_valid", 32'(b_row_valid), 32'd1);
    chk("b_r1_index", 32'(b_row_index), 32'd1);
    chk("b_r1_data", 32'(b_row_data), 32'hC3);
    chk("b_r1_errs", 32'({b_err_color, b_err_early, b_err_missing}), 32'd0);
    b_row_ready = 1'b1;
    tick();
    b_row_ready = 1'b0;
    chk("b_frame_done", 32'(b_frame_done), 32'd1);
    chk("b_frame_count", 32'(b_frame_count), 32'd1);
    chk("b_index_wrap", 32'(b_row_index), 32'd0);

    // frame table on the HEIGHT=1 decoder
    for (int i = 0; i < 7; i++) begin
      a_err_clear = 1'b1;
      tick();
      a_err_clear = 1'b0;
      chk("vec_errs_cleared", 32'({a_err_color, a_err_early, a_err_missing}), 32'd0);
      for (int k = 0; k < vecs[i].nbeats; k++)
        send_a((k == vecs[i].bad_idx) ? BAD : (vecs[i].alive[k] ? ALIVE : DEAD), k == vecs[i].last_idx);
      chk("vec_errs", 32'({a_err_color, a_err_early, a_err_missing}), 32'(vecs[i].exp_err));
      chk("vec_row_valid", 32'(a_row_valid), 32'(vecs[i].exp_row));
      if (vecs[i].exp_row) begin
        chk("vec_row_data", 32'(a_row_data), 32'(vecs[i].exp_data));
        chk("vec_row_index", 32'(a_row_index), 32'd0);
        chk("vec_tready_low", 32'(a_tready), 32'd0);
        handshake_a();
        exp_fc++;
        chk("vec_frame_done", 32'(a_frame_done), 32'd1);
        chk("vec_frame_count", 32'(a_frame_count), 32'(exp_fc));
        chk("vec_released", 32'({a_row_valid, a_tready}), 32'b01);
        tick();
        chk("vec_done_pulse", 32'(a_frame_done), 32'd0);
      end else begin
        chk("vec_tready_high", 32'(a_tready), 32'd1);
        chk("vec_no_done", 32'(a_frame_done), 32'd0);
        chk("vec_count_hold", 32'(a_frame_count), 32'(exp_fc));
        chk("vec_index_zero", 32'(a_row_index), 32'd0);
      end
    end

    // color error clear, and clear coincident with a new bad pixel
    send_a(BAD, 1'b0);
    chk("color_set", 32'(a_err_color), 32'd1);
    a_err_clear = 1'b1;
    tick();
    a_err_clear = 1'b0;
    chk("color_cleared", 32'(a_err_color), 32'd0);
    a_err_clear = 1'b1;
    send_a(BAD, 1'b0);
    a_err_clear = 1'b0;
    chk("color_clear_collide", 32'(a_err_color), 32'd1);
    for (int k = 2; k < 8; k++) send_a(ALIVE, k == 7);
    chk("color_row_data", 32'(a_row_data), 32'hFC);
    handshake_a();
    exp_fc++;
    chk("color_frame_count", 32'(a_frame_count), 32'(exp_fc));

    // reset mid-row, then a clean frame
    for (int k = 0; k < 4; k++) send_a(ALIVE, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_a("midrow_rst");
    exp_fc = 0;
    send_row_a(8'h85, 7);
    chk("post_rst_data", 32'(a_row_data), 32'h85);
    handshake_a();
    exp_fc++;
    chk("post_rst_count", 32'(a_frame_count), 32'(exp_fc));

    // reset while a row is pending
    send_row_a(8'h33, 7);
    chk("pend_valid", 32'(a_row_valid), 32'd1);
    a_row_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a_row_ready = 1'b0;
    chk_reset_a("pend_rst");
    tick();
    chk("pend_no_done", 32'(a_frame_done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
